// File: rtl/instr_fetch.sv
// Instruction fetch/sequencing stage feeding the processor's din input.
// Holds a small program memory (writable only while IDLE or HALT), steps a
// program counter through it, and hands each word over with a valid/ack
// handshake. Supports free-run, single-step and halt-on-sentinel operation.
module instr_fetch #(
  parameter int                 DATA_W    = 16,
  parameter int                 ADDR_W    = 5,
  parameter logic [DATA_W-1:0]  HALT_WORD = 16'hFFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              run,
  input  logic              step,
  input  logic              pc_clr,
  input  logic              instr_ack,
  output logic [DATA_W-1:0] din,
  output logic              din_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    READY = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              din_valid_q, din_valid_d;
  logic              halted_q, halted_d;
  logic              busy_q, busy_d;
  logic              mem_we;
  logic [DATA_W-1:0] rd_word;

  logic [DATA_W-1:0] mem_q [DEPTH];

  // The word at pc is captured into din at the edge that leaves FETCH, so a
  // write made at the edge that entered FETCH is already visible here.
  assign rd_word = mem_q[pc_q];

  // Next-state, pc, output and write-enable decode; pc_clr overrides
  // everything except reset, and also suppresses a same-cycle write.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    din_d       = din_q;
    din_valid_d = din_valid_q;
    halted_d    = halted_q;
    mem_we      = 1'b0;

    if (pc_clr) begin
      pc_d        = '0;
      din_valid_d = 1'b0;
      halted_d    = 1'b0;
      state_d     = IDLE;
    end else begin
      mem_we = wr_en && ((state_q == IDLE) || (state_q == HALT));
      unique case (state_q)
        IDLE: begin
          if (run || step) begin
            state_d = FETCH;
          end
        end
        FETCH: begin
          if (rd_word == HALT_WORD) begin
            halted_d = 1'b1;
            state_d  = HALT;
          end else begin
            din_d       = rd_word;
            din_valid_d = 1'b1;
            state_d     = READY;
          end
        end
        READY: begin
          if (instr_ack) begin
            din_valid_d = 1'b0;
            pc_d        = pc_q + ADDR_W'(1);
            state_d     = run ? FETCH : IDLE;
          end
        end
        HALT: begin
          state_d = HALT;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    busy_d = (state_d == FETCH) || (state_d == READY);
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      pc_q        <= '0;
      din_q       <= '0;
      din_valid_q <= 1'b0;
      halted_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      din_q       <= din_d;
      din_valid_q <= din_valid_d;
      halted_q    <= halted_d;
      busy_q      <= busy_d;
    end
  end

  // Program memory write port; contents survive reset, but a write is not
  // taken while reset is asserted.
  always_ff @(posedge clk) begin
    if (rst && mem_we) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign din       = din_q;
  assign din_valid = din_valid_q;
  assign pc        = pc_q;
  assign halted    = halted_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed program sequences with literal checks plus
// a cycle-by-cycle comparison against a behavioural model of the fetch unit.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data;
  logic        run;
  logic        step;
  logic        pc_clr;
  logic        instr_ack;
  logic [15:0] din;
  logic        din_valid;
  logic [4:0]  pc;
  logic        halted;
  logic        busy;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  instr_fetch #(.DATA_W(16), .ADDR_W(5), .HALT_WORD(16'hFFFF)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .run       (run),
    .step      (step),
    .pc_clr    (pc_clr),
    .instr_ack (instr_ack),
    .din       (din),
    .din_valid (din_valid),
    .pc        (pc),
    .halted    (halted),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Behavioural model: tracks whether a read is in flight, whether a word is
  // waiting for its ack, and whether the sentinel has been seen.
  logic [15:0] m_mem [32];
  logic        m_fetching = 1'b0;
  logic        m_valid    = 1'b0;
  logic        m_halt     = 1'b0;
  logic [4:0]  m_pc       = '0;
  logic [15:0] m_din      = '0;

  always @(posedge clk) begin
    if (!rst) begin
      m_fetching <= 1'b0;
      m_valid    <= 1'b0;
      m_halt     <= 1'b0;
      m_pc       <= '0;
      m_din      <= '0;
    end else if (pc_clr) begin
      m_fetching <= 1'b0;
      m_valid    <= 1'b0;
      m_halt     <= 1'b0;
      m_pc       <= '0;
    end else begin
      if (wr_en && !m_fetching && !m_valid)
        m_mem[wr_addr] <= wr_data;
      if (m_fetching) begin
        m_fetching <= 1'b0;
        if (m_mem[m_pc] == 16'hFFFF) begin
          m_halt <= 1'b1;
        end else begin
          m_din   <= m_mem[m_pc];
          m_valid <= 1'b1;
        end
      end else if (m_valid) begin
        if (instr_ack) begin
          m_valid    <= 1'b0;
          m_pc       <= 5'((int'(m_pc) + 1) % 32);
          m_fetching <= run;
        end
      end else if (!m_halt && (run || step)) begin
        m_fetching <= 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare DUT against the model on every falling edge once reset has been seen.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model din",       32'(din),       32'(m_din));
      chk("model din_valid", 32'(din_valid), 32'(m_valid));
      chk("model pc",        32'(pc),        32'(m_pc));
      chk("model halted",    32'(halted),    32'(m_halt));
      chk("model busy",      32'(busy),      32'(m_fetching || m_valid));
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic wr(input logic [4:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic pulse_clr();
    pc_clr = 1'b1;
    cyc();
    pc_clr = 1'b0;
  endtask

  task automatic step_ack(input logic [15:0] exp, input string nm);
    step = 1'b1;
    cyc();
    step = 1'b0;
    cyc();
    chk({nm, " valid"}, 32'(din_valid), 32'd1);
    chk({nm, " din"},   32'(din),       32'(exp));
    instr_ack = 1'b1;
    cyc();
    instr_ack = 1'b0;
  endtask

  function automatic logic [15:0] fill_word(input int i);
    return 16'(16'h2000 + i);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    run = 1'b0; step = 1'b0; pc_clr = 1'b0; instr_ack = 1'b0;

    // 1. Reset and load
    cyc();
    chk_en = 1'b1;
    cyc();
    chk("reset pc",        32'(pc),        32'd0);
    chk("reset din",       32'(din),       32'd0);
    chk("reset din_valid", 32'(din_valid), 32'd0);
    chk("reset halted",    32'(halted),    32'd0);
    chk("reset busy",      32'(busy),      32'd0);
    rst = 1'b1;
    for (int i = 0; i < 32; i++) wr(5'(i), fill_word(i));
    wr(5'd0, 16'h0041);
    wr(5'd1, 16'h0102);
    wr(5'd2, 16'hFFFF);
    chk("load pc",   32'(pc),   32'd0);
    chk("load busy", 32'(busy), 32'd0);

    // 2. Free run until the sentinel
    run = 1'b1;
    cyc();
    chk("run fetch busy", 32'(busy), 32'd1);
    cyc();
    chk("run word0 valid", 32'(din_valid), 32'd1);
    chk("run word0 din",   32'(din),       32'h0041);
    cyc(); cyc();
    instr_ack = 1'b1; cyc(); instr_ack = 1'b0;
    chk("run ack0 pc", 32'(pc), 32'd1);
    cyc();
    chk("run word1 din",   32'(din),       32'h0102);
    chk("run word1 valid", 32'(din_valid), 32'd1);
    cyc(); cyc();
    instr_ack = 1'b1; cyc(); instr_ack = 1'b0;
    cyc();
    chk("halt halted", 32'(halted),    32'd1);
    chk("halt pc",     32'(pc),        32'd2);
    chk("halt valid",  32'(din_valid), 32'd0);
    chk("halt din",    32'(din),       32'h0102);
    cyc(); cyc();
    chk("halt ignores run", 32'(halted), 32'd1);
    wr(5'd2, 16'h0003);
    run = 1'b0;
    pulse_clr();
    chk("clr pc",     32'(pc),     32'd0);
    chk("clr halted", 32'(halted), 32'd0);
    chk("clr busy",   32'(busy),   32'd0);

    // 3. Single step
    step_ack(16'h0041, "step0");
    chk("step0 pc", 32'(pc), 32'd1);
    chk("step0 busy", 32'(busy), 32'd0);
    cyc(); cyc(); cyc(); cyc();
    chk("step idle valid", 32'(din_valid), 32'd0);
    step_ack(16'h0102, "step1");
    step_ack(16'h0003, "step halt-written");

    // 4. Wrap-around
    pulse_clr();
    wr(5'd31, 16'h00AA);
    wr(5'd0,  16'h00BB);
    for (int i = 0; i < 31; i++) begin
      if (i == 0)      step_ack(16'h00BB, "walk");
      else if (i == 1) step_ack(16'h0102, "walk");
      else if (i == 2) step_ack(16'h0003, "walk");
      else             step_ack(fill_word(i), "walk");
    end
    chk("walk pc", 32'(pc), 32'd31);
    run = 1'b1;
    cyc(); cyc();
    chk("wrap din31", 32'(din), 32'h00AA);
    instr_ack = 1'b1; cyc(); instr_ack = 1'b0;
    chk("wrap pc", 32'(pc), 32'd0);
    cyc();
    chk("wrap din0", 32'(din), 32'h00BB);
    run = 1'b0;
    instr_ack = 1'b1; cyc(); instr_ack = 1'b0;
    chk("wrap stop pc", 32'(pc), 32'd1);
    chk("wrap stop busy", 32'(busy), 32'd0);

    // 5. Writes blocked while running
    step = 1'b1; cyc(); step = 1'b0; cyc();
    chk("blk ready din", 32'(din), 32'h0102);
    wr(5'd1, 16'h1234);
    cyc();
    instr_ack = 1'b1; cyc(); instr_ack = 1'b0;
    pulse_clr();
    step_ack(16'h00BB, "blk pc0");
    step_ack(16'h0102, "blk old word");
    wr(5'd1, 16'h1234);
    pulse_clr();
    step_ack(16'h00BB, "idle pc0");
    step_ack(16'h1234, "idle write");
    wr_en = 1'b1; wr_addr = 5'd2; wr_data = 16'h5A5A; step = 1'b1;
    cyc();
    wr_en = 1'b0; step = 1'b0;
    cyc();
    chk("write+start din", 32'(din), 32'h5A5A);
    pulse_clr();
    chk("midclr pc",    32'(pc),        32'd0);
    chk("midclr valid", 32'(din_valid), 32'd0);
    chk("midclr din",   32'(din),       32'h5A5A);

    // 6. Reset mid-operation
    step = 1'b1; cyc(); step = 1'b0; cyc();
    chk("pre-reset valid", 32'(din_valid), 32'd1);
    rst = 1'b0; instr_ack = 1'b1;
    cyc();
    chk("midrst din",   32'(din),       32'd0);
    chk("midrst valid", 32'(din_valid), 32'd0);
    chk("midrst pc",    32'(pc),        32'd0);
    chk("midrst busy",  32'(busy),      32'd0);
    cyc();
    rst = 1'b1; instr_ack = 1'b0;
    cyc(); cyc();
    chk("post-reset pc",    32'(pc),        32'd0);
    chk("post-reset valid", 32'(din_valid), 32'd0);
    step_ack(16'h00BB, "post-reset step");

    cyc();
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Instruction fetch and sequencing stage that sits directly upstream of the simple processor and drives its `din` instruction input. It holds a small synchronous program memory, loaded from board switches or a testbench while idle. A program counter steps through that memory, and each instruction word is handed to the processor with a valid/acknowledge handshake. Free-run, single-step and halt-on-sentinel modes let the DE10-Lite demo and benches sequence programs without manual switch entry per instruction.

Parameters:
DATA_W, 16, instruction/data word width; matches processor `din`.
ADDR_W, 5, program memory address width; depth = 2^ADDR_W words.
HALT_WORD, 16'hFFFF, sentinel word; fetching it stops sequencing.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous active-low reset.
wr_en  input  1  program memory write strobe; honoured only in IDLE or HALT.
wr_addr  input  ADDR_W  program memory write address.
wr_data  input  DATA_W  program memory write data.
run  input  1  level; 1 = free-run fetching.
step  input  1  one-cycle pulse; fetches exactly one instruction when run=0.
pc_clr  input  1  one-cycle pulse; pc to 0, return to IDLE, clear halted.
instr_ack  input  1  one-cycle pulse from processor control unit when it latches `din`.
din  output  DATA_W  instruction word presented to processor.
din_valid  output  1  `din` holds an unconsumed instruction.
pc  output  ADDR_W  address of the current or next instruction.
halted  output  1  HALT_WORD fetched.
busy  output  1  state is FETCH or READY.

Behaviour:
- Reset: any posedge with rst=0 sets pc=0, din=0, din_valid=0, halted=0, state IDLE. Memory contents are not cleared.
- Priority at each edge: rst, then pc_clr, then wr_en, then the FSM transition.
- States: IDLE, FETCH, READY, HALT.
- IDLE:
  - If run=1, or step=1, go to FETCH.
  - wr_en writes mem[wr_addr]=wr_data.
  - A write and a start in the same cycle are both honoured; the following fetch reads the updated word.
- FETCH:
  - Lasts one cycle; synchronous read of mem[pc].
  - At the next edge, if the word != HALT_WORD: din<=word, din_valid<=1, go to READY.
  - If the word == HALT_WORD: din unchanged, din_valid stays 0, halted<=1, go to HALT; pc is not advanced.
  - Latency: 2 edges from start request to din_valid=1.
- READY:
  - din is held stable until instr_ack.
  - On instr_ack: din_valid<=0, pc<=pc+1 (mod 2^ADDR_W), then go to FETCH if run=1, else IDLE.
  - Step mode always returns to IDLE after one ack.
  - din keeps its value after ack until the next load.
- HALT:
  - Remains until pc_clr or rst; run and step are ignored.
  - wr_en is accepted.
- wr_en in FETCH or READY is ignored (no memory change).
- instr_ack outside READY is ignored. A step pulse outside IDLE is ignored.
- run dropped while in FETCH or READY: the in-flight instruction completes and is acked; the FSM then goes to IDLE.
- Wrap-around: pc=2^ADDR_W-1 plus ack gives pc=0; sequencing continues.
- pc_clr mid-operation (FETCH or READY): pc=0, din_valid=0, state IDLE at that edge; the pending ack is lost. din is not cleared.
- busy=1 exactly in FETCH and READY; halted=1 exactly in HALT.
- All outputs are registered; no combinational path from instr_ack to din.

Test Plan:
1. Reset and load: hold rst=0 for 2 cycles, then write mem[0..2]=16'h0041, 16'h0102, 16'hFFFF with run=0 -> pc=0, din_valid=0, busy=0, halted=0 throughout.
2. Free-run with halt: assert run=1; ack each valid word 3 cycles after din_valid -> din sequence is 16'h0041 then 16'h0102, each appearing 2 cycles after start/ack. halted=1 follows, with pc=2 and din_valid=0. Then pulse pc_clr -> pc=0, halted=0, IDLE.
3. Single step: with run=0, pulse step once -> din=16'h0041, din_valid=1 after 2 cycles. Ack -> pc=1, IDLE. No further din_valid until the next step pulse.
4. Wrap-around: load mem[31]=16'h00AA and mem[0]=16'h00BB; force pc to 31 via 31 acked steps; run -> din=16'h00AA, ack -> pc=0, then din=16'h00BB.
5. Writes blocked while running: wr_en to mem[1]=16'h1234 during READY -> after completion, a step fetch at pc=1 still returns the old value. The same write in IDLE takes effect.
6. Reset mid-operation: rst=0 while in READY with din_valid=1 -> next edge din=0, din_valid=0, pc=0, IDLE. Ack pulses during reset are ignored.
